// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register that selects the writeback result and tags overflow.
// Define EX_MEM_SKID_EN to add a skid entry, which makes in_ready a registered signal.
package ex_mem_pkg;
   typedef enum logic [2:0] {
      ALU_NONE = 3'b000,
      ARITH    = 3'b001,
      LOGIC    = 3'b010,
      SHIFT    = 3'b100
   } alutype_enum;
endpackage

module ex_mem_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  ex_mem_pkg::alutype_enum alutype,
   input  logic [DATA_W-1:0]       arith_result,
   input  logic [DATA_W-1:0]       logic_result,
   input  logic [DATA_W-1:0]       shift_result,
   input  logic                    overflow,
   input  logic [31:0]             in_pc,
   input  logic                    in_wreg,
   input  logic [ADDR_W-1:0]       in_waddr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_pc,
   output logic [DATA_W-1:0]       out_wdata,
   output logic                    out_wreg,
   output logic [ADDR_W-1:0]       out_waddr,
   output logic                    out_excp_ov
);
   typedef struct packed {
      logic [31:0]       pc;
      logic [DATA_W-1:0] wdata;
      logic              wreg;
      logic [ADDR_W-1:0] waddr;
      logic              excp_ov;
   } entry_t;

   entry_t in_entry;
   entry_t main_q, main_d;
   logic   main_valid_q, main_valid_d;
   logic   accept;

   always_comb begin
      in_entry         = '0;
      in_entry.pc      = in_pc;
      in_entry.waddr   = in_waddr;
      // Overflow keeps the wrapped result but suppresses the register write.
      in_entry.excp_ov = overflow;
      in_entry.wreg    = in_wreg && !overflow;
      case (alutype)
         ex_mem_pkg::ARITH: in_entry.wdata = arith_result;
         ex_mem_pkg::LOGIC: in_entry.wdata = logic_result;
         ex_mem_pkg::SHIFT: in_entry.wdata = shift_result;
         default:           in_entry.wdata = '0;
      endcase
   end

`ifdef EX_MEM_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   main_free;

   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         // in_ready is low while skid is occupied, so no new entry competes with the refill.
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = accept;
            if (accept) main_d = in_entry;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_d       = in_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_q       <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_q       <= main_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
      end
   end
`else
   assign in_ready = !main_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (accept) begin
         main_valid_d = 1'b1;
         main_d       = in_entry;
      end else if (out_ready) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_q       <= main_d;
      end
   end
`endif

   assign out_valid   = main_valid_q;
   assign out_pc      = main_q.pc;
   assign out_wdata   = main_q.wdata;
   assign out_wreg    = main_q.wreg;
   assign out_waddr   = main_q.waddr;
   assign out_excp_ov = main_q.excp_ov;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expectations follow EX_MEM_SKID_EN when defined.
module tb_ex_mem_stage;
`ifdef EX_MEM_SKID_EN
   localparam logic SKID = 1'b1;
`else
   localparam logic SKID = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    flush = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   ex_mem_pkg::alutype_enum alutype = ex_mem_pkg::ARITH;
   logic [31:0]             arith_result = '0;
   logic [31:0]             logic_result = '0;
   logic [31:0]             shift_result = '0;
   logic                    overflow = 1'b0;
   logic [31:0]             in_pc = '0;
   logic                    in_wreg = 1'b0;
   logic [4:0]              in_waddr = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [31:0]             out_pc;
   logic [31:0]             out_wdata;
   logic                    out_wreg;
   logic [4:0]              out_waddr;
   logic                    out_excp_ov;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alutype(alutype), .arith_result(arith_result), .logic_result(logic_result),
      .shift_result(shift_result), .overflow(overflow), .in_pc(in_pc), .in_wreg(in_wreg),
      .in_waddr(in_waddr), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_wdata(out_wdata), .out_wreg(out_wreg), .out_waddr(out_waddr), .out_excp_ov(out_excp_ov)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      overflow  = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
      total++; if (out_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", out_wdata); end
      total++; if ({out_wreg, out_waddr, out_excp_ov} !== 7'h0) begin bad++; $display("FAIL rst_misc got=%b exp=0", {out_wreg, out_waddr, out_excp_ov}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      step();
   endtask

   task automatic test_arith();
      in_valid = 1'b1; alutype = ex_mem_pkg::ARITH; arith_result = 32'h5;
      logic_result = 32'h0; shift_result = 32'h0; overflow = 1'b0;
      in_pc = 32'h20; in_wreg = 1'b1; in_waddr = 5'd3; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arith_valid got=%b exp=1", out_valid); end
      total++; if (out_wdata !== 32'h5) begin bad++; $display("FAIL arith_wdata got=%h exp=5", out_wdata); end
      total++; if (out_waddr !== 5'd3) begin bad++; $display("FAIL arith_waddr got=%0d exp=3", out_waddr); end
      total++; if (out_wreg !== 1'b1) begin bad++; $display("FAIL arith_wreg got=%b exp=1", out_wreg); end
      total++; if (out_excp_ov !== 1'b0) begin bad++; $display("FAIL arith_excp got=%b exp=0", out_excp_ov); end
      total++; if (out_pc !== 32'h20) begin bad++; $display("FAIL arith_pc got=%h exp=20", out_pc); end
      idle();
   endtask

   task automatic test_select();
      in_valid = 1'b1; out_ready = 1'b1; in_wreg = 1'b1; in_waddr = 5'd9;
      arith_result = 32'h2; logic_result = 32'h1; shift_result = 32'hFFFF_FF00;
      alutype = ex_mem_pkg::SHIFT;
      step();
      total++; if (out_wdata !== 32'hFFFF_FF00) begin bad++; $display("FAIL sel_shift got=%h exp=ffffff00", out_wdata); end
      alutype = ex_mem_pkg::LOGIC;
      step();
      total++; if (out_wdata !== 32'h1) begin bad++; $display("FAIL sel_logic got=%h exp=1", out_wdata); end
      alutype = ex_mem_pkg::ARITH;
      step();
      total++; if (out_wdata !== 32'h2) begin bad++; $display("FAIL sel_arith got=%h exp=2", out_wdata); end
      alutype = ex_mem_pkg::alutype_enum'(3'b011);
      step();
      total++; if (out_wdata !== 32'h0) begin bad++; $display("FAIL sel_other got=%h exp=0", out_wdata); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sel_valid got=%b exp=1", out_valid); end
      idle();
   endtask

   task automatic test_overflow();
      in_valid = 1'b1; alutype = ex_mem_pkg::ARITH; arith_result = 32'h8000_0000;
      overflow = 1'b1; in_wreg = 1'b1; in_waddr = 5'd7; in_pc = 32'h40;
      step();
      in_valid = 1'b0; overflow = 1'b0;
      total++; if (out_excp_ov !== 1'b1) begin bad++; $display("FAIL ov_excp got=%b exp=1", out_excp_ov); end
      total++; if (out_wreg !== 1'b0) begin bad++; $display("FAIL ov_wreg got=%b exp=0", out_wreg); end
      total++; if (out_wdata !== 32'h8000_0000) begin bad++; $display("FAIL ov_wdata got=%h exp=80000000", out_wdata); end
      total++; if (out_waddr !== 5'd7) begin bad++; $display("FAIL ov_waddr got=%0d exp=7", out_waddr); end
      total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL ov_pc got=%h exp=40", out_pc); end
      idle();
   endtask

   task automatic test_backpressure();
      logic [31:0] pcs [3];
      int sent = 0;
      int got = 0;
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      alutype = ex_mem_pkg::ARITH; in_wreg = 1'b1; in_waddr = 5'd1;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (sent < 3);
         in_pc     = (sent < 3) ? pcs[sent] : 32'h0;
         arith_result = in_pc;
         @(negedge clk);
         if (cyc == 1) begin
            total++; if (in_ready !== SKID) begin bad++; $display("FAIL bp_ready_c1 got=%b exp=%b", in_ready, SKID); end
         end
         if (cyc == 2) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c2 got=%b exp=0", in_ready); end
            total++; if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin bad++; $display("FAIL bp_held got=%b/%h exp=1/100", out_valid, out_pc); end
         end
         if (out_valid && out_ready) begin
            total++; if (out_pc !== pcs[got]) begin bad++; $display("FAIL bp_order got=%h exp=%h", out_pc, pcs[got]); end
            total++; if (out_wdata !== pcs[got]) begin bad++; $display("FAIL bp_wdata got=%h exp=%h", out_wdata, pcs[got]); end
            got++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      total++; if (got !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got); end
      idle();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 32'h200; step();
      in_pc = 32'h204; step();
      total++; if ({out_valid, out_pc} !== {1'b1, 32'h200}) begin bad++; $display("FAIL fl_full got=%b/%h exp=1/200", out_valid, out_pc); end
      flush = 1'b1; in_pc = 32'h208;
      step();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_leak cyc=%0d got=%b/%h exp=0", i, out_valid, out_pc); end
      end
      // Accept attempted during flush on an empty stage must be discarded.
      in_valid = 1'b1; flush = 1'b1; in_pc = 32'h20C;
      step();
      in_valid = 1'b0; flush = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_discard got=%b/%h exp=0", out_valid, out_pc); end
      idle();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; alutype = ex_mem_pkg::LOGIC; in_wreg = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_pc = 32'h300 + 32'(i) * 32'd4;
         logic_result = 32'hA0 + 32'(i);
         in_waddr = 5'(i + 10);
         @(negedge clk);
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
         if (i > 0) begin
            total++; if ({out_valid, out_pc} !== {1'b1, 32'h300 + 32'(i - 1) * 32'd4}) begin bad++; $display("FAIL b2b_out i=%0d got=%b/%h", i, out_valid, out_pc); end
            total++; if (out_wdata !== 32'hA0 + 32'(i - 1)) begin bad++; $display("FAIL b2b_wdata i=%0d got=%h exp=%h", i, out_wdata, 32'hA0 + 32'(i - 1)); end
         end
         step();
      end
      in_valid = 1'b0;
      total++; if ({out_valid, out_pc, out_waddr} !== {1'b1, 32'h310, 5'd14}) begin bad++; $display("FAIL b2b_last got=%b/%h/%0d exp=1/310/14", out_valid, out_pc, out_waddr); end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; out_ready = 1'b0; alutype = ex_mem_pkg::ARITH;
      arith_result = 32'hDEAD_BEEF; in_pc = 32'h400; in_wreg = 1'b1; in_waddr = 5'd31; overflow = 1'b1;
      step();
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b exp=1", out_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
      total++; if ({out_pc, out_wdata} !== 64'h0) begin bad++; $display("FAIL ar_data got=%h/%h exp=0/0", out_pc, out_wdata); end
      total++; if ({out_wreg, out_waddr, out_excp_ov} !== 7'h0) begin bad++; $display("FAIL ar_misc got=%b exp=0", {out_wreg, out_waddr, out_excp_ov}); end
      in_valid = 1'b0; overflow = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_retain got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_select();
      test_overflow();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the CPU core. It consumes the three ALU result buses and the ALU overflow flag, and selects the writeback value by ALU type. It converts signed-arithmetic overflow into a tagged exception that suppresses register write, and registers the result toward the memory stage. Transfers use a valid/ready handshake with flush support, and an optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 32, datapath width (equals Data_Bus)
- ADDR_W, 5, register-file write-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush (exception/eret redirect)
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- alutype  in  alutype_enum  result class: ARITH, LOGIC or SHIFT; any other value selects zero
- arith_result  in  DATA_W  ALU arithmetic/compare result
- logic_result  in  DATA_W  ALU logic/LUI result
- shift_result  in  DATA_W  ALU shift result
- overflow  in  1  ALU signed add/sub overflow
- in_pc  in  32  instruction PC
- in_wreg  in  1  instruction writes a GPR
- in_waddr  in  ADDR_W  destination GPR
- out_valid  out  1  memory-stage entry valid
- out_ready  in  1  memory stage accepts
- out_pc  out  32  registered PC
- out_wdata  out  DATA_W  selected result
- out_wreg  out  1  write enable, forced 0 on overflow
- out_waddr  out  ADDR_W  destination GPR
- out_excp_ov  out  1  integer-overflow exception tag

## Operation
- Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Result select:
  - ARITH → arith_result
  - LOGIC → logic_result
  - SHIFT → shift_result
  - otherwise → 0
- Overflow handling when overflow=1 at transfer:
  - out_excp_ov=1 and out_wreg=0.
  - out_wdata still carries the selected (wrapped) value; out_pc, out_waddr unchanged.
- Entries leave in acceptance order; no reordering, no drops except on flush.
- flush=1 at an edge clears all valid bits, including a skid entry. Any input transfer in that same cycle is discarded. Data registers need not clear.
- Payload registers load only on accepted transfer. Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset (async, immediate):
  - out_valid=0; out_pc, out_wdata, out_waddr = 0; out_wreg=0; out_excp_ov=0.
  - Skid entry invalid; in_ready=1 once rst deasserts.
- Latency: an input accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: one transfer per cycle when out_ready stays 1.
- in_ready must not depend combinationally on in_valid.
- Simultaneous output and input transfer with a full main register: new entry replaces the main entry with no bubble.
- rst asserted mid-transfer: all state returns to reset values immediately; nothing is retained.

## Configuration
- EX_MEM_SKID_EN defined:
  - Second (skid) entry; in_ready is a flop equal to !skid_valid, with no combinational path from out_ready.
  - An input accepted while main is held (out_ready=0) goes to skid; in_ready drops the next cycle.
  - When main drains, skid moves to main in the same edge.
  - Capacity is 2 entries.
- EX_MEM_SKID_EN undefined:
  - Single register; in_ready = !out_valid || out_ready (combinational).
  - Capacity is 1 entry.
  - All other behaviour is identical.

## Test plan
- Reset, then in_valid=1, alutype=ARITH, arith_result=0x0000_0005, in_waddr=3, in_wreg=1, out_ready=1 → next cycle out_valid=1, out_wdata=5, out_waddr=3, out_wreg=1, out_excp_ov=0.
- alutype=SHIFT, shift_result=0xFFFF_FF00, LOGIC=0x1, ARITH=0x2 → out_wdata=0xFFFF_FF00; alutype outside ARITH/LOGIC/SHIFT → out_wdata=0.
- overflow=1, arith_result=0x8000_0000, in_wreg=1 → out_excp_ov=1, out_wreg=0, out_wdata=0x8000_0000.
- Backpressure:
  - out_ready=0 for 3 cycles while streaming PCs 0x100, 0x104, 0x108.
  - With EX_MEM_SKID_EN, 0x100 and 0x104 are held and in_ready=0 from the third cycle; without the macro, only 0x100 is held.
  - After release, outputs appear in order 0x100, 0x104, 0x108 with none lost.
- flush=1 while main and skid are full and in_valid=1 → next cycle out_valid=0; no flushed PC is ever presented.
- rst pulsed high mid-stream with out_valid=1 → out_valid=0 and all outputs 0 immediately, without waiting for clk.
